router_pkt_fifo: RTL
====================

# router_pkt_fifo

Parametrised, packet-aware successor to the router's per-port output FIFO. It sits between the router's write-side FSM and one destination port. It stores header-tagged words with a start-of-packet flag and tracks packet boundaries on the read side. It reports occupancy, almost-full, packets resident, and sticky overflow, underflow and framing errors, with no tri-state output.

## Interface
- WIDTH, 8, data word width; header format {payload_len[WIDTH-1:2], addr[1:0]}; WIDTH >= 4
- DEPTH, 16, storage depth in words; power of 2, >= 4
- AFULL_TH, DEPTH-2, occupancy at or above which almost_full asserts
- clk  in  1  single clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- soft_reset  in  1  synchronous flush, active-high
- write_enb  in  1  push request
- read_enb  in  1  pop request
- lfd_state  in  1  marks data_in as packet header (SOP)
- data_in  in  WIDTH  write data
- data_out  out  WIDTH  registered read data
- rd_valid  out  1  data_out updated this cycle (one pulse per pop)
- rd_sop  out  1  popped word was a header
- rd_eop  out  1  popped word was the packet's parity (last) word
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AFULL_TH
- count  out  $clog2(DEPTH)+1  occupancy
- pkt_cnt  out  $clog2(DEPTH)+1  packets resident (SOP written, EOP not yet popped)
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty
- pkt_err  out  1  sticky: header popped before previous packet's EOP

## Operation
- Storage: DEPTH x (WIDTH+1); bit WIDTH holds lfd_state captured with the word.
- Pointers: $clog2(DEPTH) bits each, wrap modulo DEPTH. Occupancy comes from an explicit count register.
- Push accepted iff write_enb && !full, where full is the registered value from the start of the cycle. A write at full is dropped even if a pop happens in the same cycle, and it sets overflow.
- Pop accepted iff read_enb && !empty. A read at empty is ignored, even if a push happens in the same cycle, and it sets underflow.
- Simultaneous accepted push and pop leaves count unchanged.
- Read-side packet tracking uses a register rem, WIDTH-1 bits:
  - Pop of an SOP word: rem <= data[WIDTH-1:2] + 1 (payload words + parity). Set rd_sop. If rem != 0 before this pop, set pkt_err.
  - Pop of a non-SOP word with rem > 1: rem <= rem - 1.
  - Pop with rem == 1: rd_eop = 1, rem <= 0, pkt_cnt decrements.
  - Pop of a non-SOP word with rem == 0 (orphan word): no eop; set pkt_err.
- pkt_cnt increments on an accepted push with lfd_state=1. Increment and decrement in the same cycle cancel.
- Zero-length header (payload_len = 0): rem = 1, so the next pop is the EOP.
- soft_reset: clears pointers, count, pkt_cnt, rem, all flags and data_out. A push or pop in the same cycle is ignored. Storage contents are not cleared.
- Precedence: resetn > soft_reset > push/pop.

## Timing
- Reset values (resetn low, applied immediately, asynchronous): data_out=0, rd_valid=0, rd_sop=0, rd_eop=0, full=0, empty=1, almost_full=0, count=0, pkt_cnt=0, overflow=0, underflow=0, pkt_err=0.
- All outputs are registered; the status flags are decoded from next-state count.
- Push on edge N: count, empty, full and almost_full reflect it after edge N.
- Pop latency 1: after the accepting edge, data_out, rd_valid, rd_sop and rd_eop present the word for exactly one cycle. data_out holds its last value when rd_valid=0.
- Write-to-read: a word pushed at edge N can be popped at edge N+1. It appears on data_out after N+1.
- Sticky flags set on the edge of the offending request. They are cleared only by resetn or soft_reset.
- Releasing resetn: the first push is accepted on the first rising edge with resetn high.

## Test plan
- **Reset:** hold resetn=0 mid-stream, asynchronously. All outputs must immediately take their reset values, with empty=1 and count=0.
- **Fill and overflow:** at WIDTH=8, DEPTH=16, write header 0x38 (len 14, addr 0) with lfd_state=1, then 14 payload words and 1 parity word.
  - Required after the 16 writes: full=1, count=16, pkt_cnt=1, almost_full high from count 14.
  - A 17th write is dropped and sets overflow=1; count stays 16.
- **Drain:** read 16 times from the filled state.
  - First pop: data_out=0x38, rd_sop=1.
  - 16th pop: rd_eop=1, pkt_cnt=0, empty=1.
  - A 17th read sets underflow=1.
- **Concurrent access:**
  - Push and pop together at count=8: count stays 8.
  - Push and pop together at full: only the pop is taken, count goes to 15, overflow=1.
  - Push and pop together at empty: only the push is taken, rd_valid=0, underflow=1.
- **Soft reset mid-packet:** write 5 words, then pulse soft_reset together with write_enb=1.
  - Required: count=0, empty=1, pkt_cnt=0, all flags 0, the same-cycle write dropped.
  - A following packet then reads back correctly, including across pointer wrap after 20 total writes.
- **Framing:**
  - Zero-length header 0x01 followed by parity: EOP on the second pop.
  - Header, 2 payload words, then a new header: pkt_err=1 when the second header pops, and rem reloads from the new header.

Source files
------------

// File: rtl/router_pkt_fifo.sv
// Packet-aware output FIFO for one router destination port.
// Stores words with an SOP tag, tracks packet framing on the read side and reports sticky errors.
module router_pkt_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AFULL_TH = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       soft_reset,
  input  logic                       write_enb,
  input  logic                       read_enb,
  input  logic                       lfd_state,
  input  logic [WIDTH-1:0]           data_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       rd_valid,
  output logic                       rd_sop,
  output logic                       rd_eop,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     pkt_cnt,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       pkt_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = WIDTH - 1;

  logic [WIDTH:0]     r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]      r_count, r_pkt_cnt;
  logic [RW-1:0]      r_rem;
  logic [WIDTH-1:0]   r_data_out;
  logic               r_rd_valid, r_rd_sop, r_rd_eop;
  logic               r_full, r_empty, r_afull;
  logic               r_overflow, r_underflow, r_pkt_err;

  logic               w_push, w_pop;
  logic [WIDTH:0]     w_rd_word;
  logic               w_rd_sop;
  logic [WIDTH-3:0]   w_len;
  logic [RW-1:0]      w_rem_nxt;
  logic               w_eop, w_frame_err;
  logic [CW-1:0]      w_count_nxt, w_pkt_nxt;

  // Full/empty are the registered values from the start of the cycle, so a
  // same-cycle pop never rescues a write at full (and vice versa at empty).
  assign w_push    = write_enb && !r_full;
  assign w_pop     = read_enb && !r_empty;
  assign w_rd_word = r_mem[r_rd_ptr];
  assign w_rd_sop  = w_rd_word[WIDTH];
  assign w_len     = w_rd_word[WIDTH-1:2];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_rem_nxt   = r_rem;
    w_eop       = 1'b0;
    w_frame_err = 1'b0;
    if (w_pop) begin
      if (w_rd_sop) begin
        w_rem_nxt   = {1'b0, w_len} + RW'(1);
        w_frame_err = (r_rem != '0);
      end else if (r_rem == RW'(1)) begin
        w_eop     = 1'b1;
        w_rem_nxt = '0;
      end else if (r_rem != '0) begin
        w_rem_nxt = r_rem - RW'(1);
      end else begin
        w_frame_err = 1'b1;
      end
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
    w_pkt_nxt = r_pkt_cnt;
    case ({w_push && lfd_state, w_eop})
      2'b10:   w_pkt_nxt = r_pkt_cnt + CW'(1);
      2'b01:   w_pkt_nxt = r_pkt_cnt - CW'(1);
      default: w_pkt_nxt = r_pkt_cnt;
    endcase
  end

  // NOTE: storage has no reset; occupancy and pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push && !soft_reset) r_mem[r_wr_ptr] <= {lfd_state, data_in};
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_pkt_cnt   <= '0;
      r_rem       <= '0;
      r_data_out  <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_sop    <= 1'b0;
      r_rd_eop    <= 1'b0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_afull     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_pkt_err   <= 1'b0;
    end else if (soft_reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_pkt_cnt   <= '0;
      r_rem       <= '0;
      r_data_out  <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_sop    <= 1'b0;
      r_rd_eop    <= 1'b0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_afull     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_pkt_err   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + AW'(1);
        r_data_out <= w_rd_word[WIDTH-1:0];
      end
      r_rd_valid  <= w_pop;
      r_rd_sop    <= w_pop && w_rd_sop;
      r_rd_eop    <= w_eop;
      r_rem       <= w_rem_nxt;
      r_count     <= w_count_nxt;
      r_pkt_cnt   <= w_pkt_nxt;
      r_full      <= (w_count_nxt == CW'(DEPTH));
      r_empty     <= (w_count_nxt == '0);
      r_afull     <= (w_count_nxt >= CW'(AFULL_TH));
      if (write_enb && r_full) r_overflow  <= 1'b1;
      if (read_enb && r_empty) r_underflow <= 1'b1;
      if (w_frame_err)         r_pkt_err   <= 1'b1;
    end
  end

  assign data_out    = r_data_out;
  assign rd_valid    = r_rd_valid;
  assign rd_sop      = r_rd_sop;
  assign rd_eop      = r_rd_eop;
  assign full        = r_full;
  assign empty       = r_empty;
  assign almost_full = r_afull;
  assign count       = r_count;
  assign pkt_cnt     = r_pkt_cnt;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;
  assign pkt_err     = r_pkt_err;

endmodule
